// File: rtl/crank_angle_interp.sv
// rtl/crank_angle_interp.sv - fine crank angle interpolator between wheel teeth (option: CRANK_ANGLE_INTERP_STATS_EN adds clamp_cnt)
module crank_angle_interp #(
  parameter int FRAC_BITS = 2,
  parameter int CYCLE_DEG = 720
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trigger,
  input  logic                   synced,
  input  logic [15:0]            eng_phase,
  input  logic [31:0]            tooth_period,
  input  logic [15:0]            next_tooth_length_deg,
  input  logic [15:0]            tooth_width_deg,
  output logic [16+FRAC_BITS-1:0] angle,
  output logic                   angle_valid,
  output logic                   div_busy
`ifdef CRANK_ANGLE_INTERP_STATS_EN
  ,
  output logic [15:0]            clamp_cnt
`endif
);

  localparam int AW = 16 + FRAC_BITS;
  localparam logic [33:0]   CYCLE_Q   = 34'(CYCLE_DEG) << FRAC_BITS;
  localparam logic [AW-1:0] ANGLE_MAX = AW'(CYCLE_Q - 34'd1);

  // Interpolation state
  logic [31:0]   step_period;
  logic [31:0]   step_cnt;
  logic [AW-1:0] limit;

  // Restoring divider state; dvd_q holds the dividend and collects quotient bits
  logic [31:0] dvd_q;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  div_cnt;

  logic          accept;
  logic [33:0]   span_q;
  logic [AW-1:0] limit_next;
  logic [32:0]   rem_shift;
  logic          q_bit;
  logic [31:0]   rem_next;
  logic [31:0]   quot_next;
  logic [31:0]   quot_final;
  logic          step_due;
  logic          at_limit;
  logic          step_event;
  logic [AW-1:0] angle_inc;

  assign accept = trigger && synced;

  // Last fine step before the next expected tooth, wrapped into the engine cycle
  always_comb begin
    span_q     = (34'(eng_phase) + 34'(next_tooth_length_deg)) << FRAC_BITS;
    limit_next = AW'((span_q + CYCLE_Q - 34'd1) % CYCLE_Q);
  end

  // One restoring division step, plus the degenerate-result substitution on the last bit
  always_comb begin
    rem_shift = {rem, dvd_q[31]};
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_next  = q_bit ? 32'(rem_shift - {1'b0, dvs}) : rem_shift[31:0];
    quot_next = {dvd_q[30:0], q_bit};
    if (dvs == 32'd0) begin
      quot_final = 32'hFFFF_FFFF;
    end else if (quot_next == 32'd0) begin
      quot_final = 32'd1;
    end else begin
      quot_final = quot_next;
    end
  end

  // Step timing and clamp/wrap of the next angle value
  always_comb begin
    step_due   = ({1'b0, step_cnt} + 33'd1) >= {1'b0, step_period};
    at_limit   = (angle == limit);
    step_event = angle_valid && (step_period != 32'd0) && step_due;
    angle_inc  = (angle == ANGLE_MAX) ? '0 : angle + AW'(1);
  end

  // Tooth capture, divider sequencing and angle stepping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle       <= '0;
      angle_valid <= 1'b0;
      div_busy    <= 1'b0;
      step_period <= '0;
      step_cnt    <= '0;
      limit       <= '0;
      dvd_q       <= '0;
      dvs         <= '0;
      rem         <= '0;
      div_cnt     <= '0;
    end else if (!synced) begin
      // Sync loss: angle holds, everything rate-related is discarded
      angle_valid <= 1'b0;
      step_period <= '0;
      step_cnt    <= '0;
      div_busy    <= 1'b0;
      div_cnt     <= '0;
    end else if (trigger) begin
      angle       <= {eng_phase, {FRAC_BITS{1'b0}}};
      limit       <= limit_next;
      step_cnt    <= '0;
      angle_valid <= 1'b1;
      div_busy    <= 1'b1;
      dvd_q       <= tooth_period;
      dvs         <= {16'd0, tooth_width_deg} << FRAC_BITS;
      rem         <= '0;
      div_cnt     <= '0;
    end else begin
      if (div_busy) begin
        dvd_q   <= quot_next;
        rem     <= rem_next;
        div_cnt <= div_cnt + 5'd1;
        if (div_cnt == 5'd31) begin
          step_period <= quot_final;
          div_busy    <= 1'b0;
        end
      end
      // The previous step_period keeps pacing the angle while a division runs
      if (angle_valid && step_period != 32'd0) begin
        if (step_due) begin
          step_cnt <= '0;
          if (!at_limit) begin
            angle <= angle_inc;
          end
        end else begin
          step_cnt <= step_cnt + 32'd1;
        end
      end
    end
  end

`ifdef CRANK_ANGLE_INTERP_STATS_EN
  logic clamp_flag;

  // Count tooth intervals where the clamp held the angle at least once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clamp_cnt  <= '0;
      clamp_flag <= 1'b0;
    end else if (accept) begin
      clamp_flag <= 1'b0;
    end else if (synced && step_event && at_limit && !clamp_flag) begin
      clamp_flag <= 1'b1;
      if (clamp_cnt != 16'hFFFF) begin
        clamp_cnt <= clamp_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crank_angle_interp.sv
// tb/tb_crank_angle_interp.sv - directed self-checking bench for crank_angle_interp
module tb_crank_angle_interp;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic        synced;
  logic [15:0] eng_phase;
  logic [31:0] tooth_period;
  logic [15:0] next_tooth_length_deg;
  logic [15:0] tooth_width_deg;
  logic [17:0] angle;
  logic        angle_valid;
  logic        div_busy;
`ifdef CRANK_ANGLE_INTERP_STATS_EN
  logic [15:0] clamp_cnt;
`endif

  int n_checks;
  int n_fail;

  crank_angle_interp #(.FRAC_BITS(2), .CYCLE_DEG(720)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .trigger               (trigger),
    .synced                (synced),
    .eng_phase             (eng_phase),
    .tooth_period          (tooth_period),
    .next_tooth_length_deg (next_tooth_length_deg),
    .tooth_width_deg       (tooth_width_deg),
    .angle                 (angle),
    .angle_valid           (angle_valid),
    .div_busy              (div_busy)
`ifdef CRANK_ANGLE_INTERP_STATS_EN
    ,
    .clamp_cnt             (clamp_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire(input logic [15:0] ph, input logic [15:0] nl, input logic [31:0] per, input logic [15:0] w);
    eng_phase             = ph;
    next_tooth_length_deg = nl;
    tooth_period          = per;
    tooth_width_deg       = w;
    trigger               = 1'b1;
    tick(1);
    trigger               = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    trigger = 1'b0;
    synced = 1'b1;
    eng_phase = '0;
    tooth_period = '0;
    next_tooth_length_deg = '0;
    tooth_width_deg = '0;
    tick(2);
    check_eq("rst_angle", 32'(angle), 0);
    check_eq("rst_valid", 32'(angle_valid), 0);
    check_eq("rst_busy", 32'(div_busy), 0);
    rst_n = 1'b1;
    tick(1);

    // Basic interpolation: 2400 / (6<<2) = 100 clocks per step, limit 143
    fire(16'd30, 16'd6, 32'd2400, 16'd6);
    check_eq("basic_load", 32'(angle), 120);
    check_eq("basic_valid", 32'(angle_valid), 1);
    check_eq("basic_busy_t1", 32'(div_busy), 1);
    tick(31);
    check_eq("basic_busy_t32", 32'(div_busy), 1);
    tick(1);
    check_eq("basic_busy_t33", 32'(div_busy), 0);
    check_eq("basic_period", dut.step_period, 100);
    tick(99);
    check_eq("basic_before_step", 32'(angle), 120);
    tick(1);
    check_eq("basic_first_step", 32'(angle), 121);
    tick(2200);
    check_eq("basic_reach_clamp", 32'(angle), 143);
    tick(300);
    check_eq("basic_clamp_hold", 32'(angle), 143);

    // Missing-tooth span: 18 degrees, no early clamp
    fire(16'd342, 16'd18, 32'd2400, 16'd6);
    check_eq("gap_load", 32'(angle), 1368);
    tick(7000);
    check_eq("gap_mid", 32'(angle), 1438);
    tick(100);
    check_eq("gap_end", 32'(angle), 1439);
    tick(200);
    check_eq("gap_hold", 32'(angle), 1439);
    fire(16'd0, 16'd6, 32'd2400, 16'd6);
    check_eq("gap_next_zero", 32'(angle), 0);

    // Wrap: clamp at cycle end, then limit that wraps past 0
    fire(16'd714, 16'd6, 32'd2400, 16'd6);
    check_eq("wrap_load", 32'(angle), 2856);
    tick(2400);
    check_eq("wrap_clamp_top", 32'(angle), 2879);
    fire(16'd0, 16'd6, 32'd2400, 16'd6);
    check_eq("wrap_trig_zero", 32'(angle), 0);
    fire(16'd714, 16'd12, 32'd2400, 16'd6);
    tick(2300);
    check_eq("wrap_top", 32'(angle), 2879);
    tick(100);
    check_eq("wrap_to_zero", 32'(angle), 0);
    tick(2300);
    check_eq("wrap_clamp_23", 32'(angle), 23);
    tick(200);
    check_eq("wrap_hold_23", 32'(angle), 23);

    // Sync loss mid-tooth
    synced = 1'b0;
    tick(1);
    check_eq("loss_valid", 32'(angle_valid), 0);
    check_eq("loss_angle", 32'(angle), 23);
    check_eq("loss_period", dut.step_period, 0);
    tick(5);
    check_eq("loss_frozen", 32'(angle), 23);
    check_eq("loss_busy", 32'(div_busy), 0);
    synced = 1'b1;

    // Re-sync, then re-trigger at T+10 with half the period
    fire(16'd30, 16'd6, 32'd2400, 16'd6);
    check_eq("resync_load", 32'(angle), 120);
    check_eq("resync_valid", 32'(angle_valid), 1);
    tick(9);
    fire(16'd30, 16'd6, 32'd1200, 16'd6);
    tick(22);
    check_eq("retrig_no_old_q", dut.step_period, 0);
    check_eq("retrig_busy_t33", 32'(div_busy), 1);
    tick(9);
    check_eq("retrig_busy_t42", 32'(div_busy), 1);
    check_eq("retrig_no_step", 32'(angle), 120);
    tick(1);
    check_eq("retrig_busy_t43", 32'(div_busy), 0);
    check_eq("retrig_period", dut.step_period, 50);

    // Reset in the middle of a division
    fire(16'd30, 16'd6, 32'd2400, 16'd6);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check_eq("midrst_angle", 32'(angle), 0);
    check_eq("midrst_valid", 32'(angle_valid), 0);
    check_eq("midrst_busy", 32'(div_busy), 0);
    check_eq("midrst_period", dut.step_period, 0);
    rst_n = 1'b1;
    tick(1);

    // Zero tooth width: saturated period, angle never moves
    fire(16'd30, 16'd6, 32'd2400, 16'd0);
    tick(32);
    check_eq("div0_period", dut.step_period, 32'hFFFF_FFFF);
    check_eq("div0_busy", 32'(div_busy), 0);
    tick(200);
    check_eq("div0_hold", 32'(angle), 120);

`ifdef CRANK_ANGLE_INTERP_STATS_EN
    // One tooth clamped for two step events counts once
    check_eq("stats_zero", 32'(clamp_cnt), 0);
    fire(16'd30, 16'd1, 32'd2400, 16'd6);
    tick(600);
    check_eq("stats_angle", 32'(angle), 123);
    check_eq("stats_one", 32'(clamp_cnt), 1);
    fire(16'd30, 16'd1, 32'd2400, 16'd6);
    check_eq("stats_after_trig", 32'(clamp_cnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crank_angle_interp.md
Name: crank_angle_interp

Overview:
- Sits directly downstream of the crank-wheel sync stage.
- Consumes its per-tooth outputs: trigger pulse, synced, coarse tooth phase, measured tooth period and next-tooth span.
- Produces a fine-resolution engine angle that advances smoothly between teeth, for the injection and ignition schedulers.
- Rate is set by an iterative divider (clocks per angle step); a clamp stops the angle from running past the next expected tooth.

Parameters:
- FRAC_BITS, 2, fractional angle bits; one step = 1/2^FRAC_BITS degree.
- CYCLE_DEG, 720, engine cycle length in degrees; the angle wraps here.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- trigger  in  1  one-cycle tooth pulse from sync; only asserted while synced
- synced  in  1  sync stage locked
- eng_phase  in  16  coarse tooth angle in degrees; valid in the trigger cycle
- tooth_period  in  32  clocks of the last short tooth; valid in the trigger cycle
- next_tooth_length_deg  in  16  degrees until the next expected trigger
- tooth_width_deg  in  16  nominal short-tooth width in degrees
- angle  out  16+FRAC_BITS  fine engine angle, unit 2^-FRAC_BITS degree
- angle_valid  out  1  angle is trustworthy
- div_busy  out  1  divider running

Behaviour:
- Reset (rst_n=0 at a clk edge): angle=0, angle_valid=0, div_busy=0, step_period=0, step_cnt=0, limit=0, divider state idle. Reset mid-division aborts it; no partial quotient is kept.
- Trigger accept (trigger=1 and synced=1, cycle T):
  - angle <= eng_phase<<FRAC_BITS, visible at T+1.
  - limit <= (eng_phase+next_tooth_length_deg)<<FRAC_BITS, minus one step, modulo CYCLE_DEG<<FRAC_BITS.
  - step_cnt <= 0; angle_valid <= 1.
  - Divider starts: dividend = tooth_period, divisor = tooth_width_deg<<FRAC_BITS (32-bit, zero-extended).
- Divider: restoring, one quotient bit per cycle, 32 iterations.
  - div_busy=1 from T+1 through T+32; step_period is loaded at T+33.
  - Quotient 0 loads 1.
  - Divisor 0 loads 32'hFFFFFFFF, which effectively freezes stepping.
  - A trigger while busy restarts the divider with the new operands; the old result is discarded.
- Stepping (each cycle, angle_valid=1, step_period!=0, no trigger):
  - step_cnt increments.
  - When step_cnt+1 >= step_period: step_cnt <= 0 and angle advances one step, unless angle == limit (clamp: hold).
  - While the divider runs, the previous step_period keeps driving stepping.
  - step_period=0 (first tooth after reset or sync loss) means angle holds.
- Wrap: the increment from (CYCLE_DEG<<FRAC_BITS)-1 goes to 0.
- Sync loss: synced=0 in any cycle gives angle_valid <= 0 next cycle, step_period <= 0, and an aborted divider. angle holds its last value.
- Simultaneous events:
  - trigger has priority over the step increment and the clamp in the same cycle.
  - synced=0 has priority over trigger.

Optional Feature:
- Macro: CRANK_ANGLE_INTERP_STATS_EN.
- Enabled:
  - Adds output clamp_cnt[15:0], reset 0.
  - Increments (saturating at 16'hFFFF) once per tooth interval in which the clamp held the angle for at least one step event.
  - The per-tooth flag clears on trigger accept.
- Disabled: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic interpolation (FRAC_BITS=2, tooth_width_deg=6, tooth_period=2400): step_period=100. Trigger eng_phase=30, next_len=6 → angle=120 at T+1; 120→121 exactly 100 clocks after the first step edge; clamps at 143.
- Missing-tooth span (next_tooth_length_deg=18, eng_phase=342, tooth_period=2400): angle advances 1368 to 1439 at 100 clk/step with no early clamp; next trigger with eng_phase=0 loads 0.
- Wrap (CYCLE_DEG=720, eng_phase=714, next_len=6, step_period=100): angle climbs from 2856 to the clamp at 2879 and holds; no wrap occurs inside one tooth. Trigger with eng_phase=0 → angle=0. Separately, next_len=12 → angle reaches 2879, then 0, then clamps at 23 (limit wraps too).
- Re-trigger during division: second trigger at T+10 with tooth_period=1200 → div_busy stays high to T+42; step_period=50 at T+43; the first quotient is never loaded.
- Sync loss and reset: synced low mid-tooth → angle_valid=0 next cycle, angle frozen, step_period=0. Re-sync trigger → angle loaded and no stepping until the divider completes. Then rst_n low mid-division → all outputs 0 the next cycle.
- Degenerate divisor: tooth_width_deg=0 → step_period=FFFFFFFF and the angle never steps. With CRANK_ANGLE_INTERP_STATS_EN: a tooth clamped for two steps raises clamp_cnt by exactly 1.
